// File: rtl/result_drain.sv
// Drains ARRAY_SIZE result words from the outcome SRAM onto a valid/ready stream.
// Optional DRAIN_CHECKSUM_EN adds a running XOR checksum of the handshaken words.
module result_drain #(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] pop_cnt;
  logic                  pending;
  logic [1:0]            fifo_count;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [3];

  logic issue;
  logic push;
  logic pop;
  logic start_acc;
  logic last_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit uses registered count and in-flight flag only, so out_ready never reaches sram_csb.
  always_comb begin
    issue     = (state == DRAIN) && (({1'b0, fifo_count} + {2'b00, pending}) < 3'd3);
    push      = pending;
    out_valid = (fifo_count != 2'd0);
    pop       = out_valid && out_ready;
    start_acc = (state == IDLE) && start;
    last_pop  = pop && (pop_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (issue && (rd_cnt == LAST_IDX)) state_nxt = FLUSH;
      FLUSH:   if (last_pop) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == DRAIN) || (state == FLUSH);
    done     = (state == DONE);
    sram_csb = !issue;
  end

  assign sram_raddr = rd_cnt;

  always_ff @(posedge clk) begin
    if (srst || start_acc) begin
      rd_cnt     <= '0;
      pop_cnt    <= '0;
      pending    <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      pending <= issue;
      if (issue && (rd_cnt != LAST_IDX)) rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        pop_cnt <= pop_cnt + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

  // Head fields are forced to zero while empty so the reset/idle view is clean.
  always_comb begin
    out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    out_index = out_valid ? pop_cnt : '0;
    out_last  = out_valid && (pop_cnt == LAST_IDX);
  end

`ifdef DRAIN_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (srst || start_acc) checksum <= '0;
    else if (pop)          checksum <= checksum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain with a 1-cycle-latency SRAM model.
// Build with DRAIN_CHECKSUM_EN defined to include the checksum scenario.
module tb_result_drain;
  localparam int AS = 32;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          srst, start, busy, done, sram_csb;
  logic [AW-1:0] sram_raddr, out_index;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;
`ifdef DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  result_drain #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .srst(srst), .start(start), .busy(busy), .done(done),
    .sram_csb(sram_csb), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
`ifdef DRAIN_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [AS];
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records handshakes and events; all comparisons live in the tests.
  logic [DW-1:0] hs_data [$];
  int            hs_idx  [$];
  logic          hs_last [$];
  int            hs_cyc  [$];
  int issues, dones, done_cyc, stab_err, max_out;
  logic          stall_prev;
  logic [DW-1:0] pd;
  logic [AW-1:0] pi;
  logic          pl;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_data.push_back(out_data);
      hs_idx.push_back(int'(out_index));
      hs_last.push_back(out_last);
      hs_cyc.push_back(cyc);
    end
    if (!sram_csb) issues++;
    if (done) begin dones++; done_cyc = cyc; end
    if (stall_prev && out_valid && (out_data !== pd || out_index !== pi || out_last !== pl))
      stab_err++;
    stall_prev = out_valid && !out_ready;
    pd = out_data; pi = out_index; pl = out_last;
    if (issues - int'(hs_data.size()) > max_out) max_out = issues - int'(hs_data.size());
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    hs_data.delete(); hs_idx.delete(); hs_last.delete(); hs_cyc.delete();
    issues = 0; dones = 0; done_cyc = 0; stab_err = 0; max_out = 0; stall_prev = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1; s = cyc; tick(); start = 1'b0;
  endtask

  task automatic preload(input logic [DW-1:0] base);
    for (int i = 0; i < AS; i++) mem[i] = base + DW'(i);
  endtask

  task automatic test_reset();
    srst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (sram_csb !== 1'b1 || sram_raddr !== '0) $display("FAIL reset_sram: csb=%b raddr=%0d want 1 0", sram_csb, sram_raddr);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0)
      $display("FAIL reset_out: valid=%b data=%h idx=%0d last=%b want all 0", out_valid, out_data, out_index, out_last);
    else pass_cnt++;
`ifdef DRAIN_CHECKSUM_EN
    total_cnt++;
    if (checksum !== '0) $display("FAIL reset_checksum: got %h want 0", checksum);
    else pass_cnt++;
`endif
    srst = 1'b0; tick();
  endtask

  task automatic test_stream();
    int s;
    preload(32'h3F80_0000);
    clear_mon(); out_ready = 1'b1;
    pulse_start(s);
    total_cnt++;
    if (busy !== 1'b1 || sram_csb !== 1'b0 || sram_raddr !== '0)
      $display("FAIL stream_first_issue: busy=%b csb=%b raddr=%0d want 1 0 0", busy, sram_csb, sram_raddr);
    else pass_cnt++;
    while (cyc < s + 35) tick();
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL stream_done_s35: done=%b busy=%b want 1 0", done, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL stream_done_pulse: done=%b at S+36 want 0", done);
    else pass_cnt++;
    total_cnt++;
    if (hs_data.size() != AS || dones != 1) $display("FAIL stream_count: words=%0d dones=%0d want 32 1", hs_data.size(), dones);
    else pass_cnt++;
    for (int i = 0; i < hs_data.size(); i++) begin
      total_cnt++;
      if (hs_data[i] !== 32'h3F80_0000 + DW'(i) || hs_idx[i] != i || hs_last[i] !== (i == AS - 1) || hs_cyc[i] != s + 3 + i)
        $display("FAIL stream_word[%0d]: data=%h idx=%0d last=%b cyc=%0d want %h %0d %b %0d", i, hs_data[i], hs_idx[i],
                 hs_last[i], hs_cyc[i] - s, 32'h3F80_0000 + DW'(i), i, (i == AS - 1), 3 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_toggle();
    int s;
    clear_mon(); out_ready = 1'b1;
    pulse_start(s);
    for (int n = 0; n < 300 && dones == 0; n++) begin tick(); out_ready = ~out_ready; end
    out_ready = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (hs_data.size() != AS || dones != 1) $display("FAIL toggle_count: words=%0d dones=%0d want 32 1", hs_data.size(), dones);
    else pass_cnt++;
    for (int i = 0; i < hs_data.size(); i++) begin
      total_cnt++;
      if (hs_data[i] !== 32'h3F80_0000 + DW'(i) || hs_idx[i] != i)
        $display("FAIL toggle_word[%0d]: data=%h idx=%0d want %h %0d", i, hs_data[i], hs_idx[i], 32'h3F80_0000 + DW'(i), i);
      else pass_cnt++;
    end
    total_cnt++;
    if (stab_err != 0 || max_out > 3) $display("FAIL toggle_stall: unstable=%0d max_buffered=%0d want 0 <=3", stab_err, max_out);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int s;
    clear_mon(); out_ready = 1'b0;
    pulse_start(s);
    repeat (19) tick();
    total_cnt++;
    if (issues != 3 || hs_data.size() != 0) $display("FAIL stall_issues: reads=%0d words=%0d want 3 0", issues, hs_data.size());
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_index !== '0)
      $display("FAIL stall_head: valid=%b data=%h idx=%0d want 1 3f800000 0", out_valid, out_data, out_index);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) tick();
    total_cnt++;
    if (hs_data.size() != AS || dones != 1 || stab_err != 0 || max_out > 3)
      $display("FAIL stall_finish: words=%0d dones=%0d unstable=%0d max_buffered=%0d want 32 1 0 <=3",
               hs_data.size(), dones, stab_err, max_out);
    else pass_cnt++;
    for (int i = 0; i < hs_data.size(); i++) begin
      total_cnt++;
      if (hs_data[i] !== 32'h3F80_0000 + DW'(i) || hs_idx[i] != i)
        $display("FAIL stall_word[%0d]: data=%h idx=%0d want %h %0d", i, hs_data[i], hs_idx[i], 32'h3F80_0000 + DW'(i), i);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int s;
    tick();
    clear_mon(); out_ready = 1'b1;
    pulse_start(s);
    while (cyc < s + 10) tick();
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < s + 35) tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL ignore_done_s35: done=%b want 1", done);
    else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || hs_data.size() != AS || dones != 1)
      $display("FAIL ignore_first: busy=%b words=%0d dones=%0d want 0 32 1", busy, hs_data.size(), dones);
    else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 200 && dones < 2; n++) tick();
    total_cnt++;
    if (hs_data.size() != 2 * AS || dones != 2) $display("FAIL ignore_second: words=%0d dones=%0d want 64 2", hs_data.size(), dones);
    else pass_cnt++;
    for (int i = AS; i < hs_data.size(); i++) begin
      total_cnt++;
      if (hs_data[i] !== 32'h3F80_0000 + DW'(i - AS) || hs_idx[i] != i - AS)
        $display("FAIL ignore_word[%0d]: data=%h idx=%0d want %h %0d", i, hs_data[i], hs_idx[i], 32'h3F80_0000 + DW'(i - AS), i - AS);
      else pass_cnt++;
    end
  endtask

  task automatic test_srst();
    int s;
    tick();
    clear_mon(); out_ready = 1'b1;
    pulse_start(s);
    while (cyc < s + 15) tick();
    srst = 1'b1; start = 1'b1; tick(); srst = 1'b0; start = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sram_csb !== 1'b1)
      $display("FAIL srst_abort: valid=%b busy=%b csb=%b want 0 0 1", out_valid, busy, sram_csb);
    else pass_cnt++;
    repeat (2) tick();
    clear_mon();
    pulse_start(s);
    for (int n = 0; n < 200 && dones == 0; n++) tick();
    total_cnt++;
    if (hs_data.size() != AS || dones != 1) $display("FAIL srst_restart_count: words=%0d dones=%0d want 32 1", hs_data.size(), dones);
    else pass_cnt++;
    for (int i = 0; i < hs_data.size(); i++) begin
      total_cnt++;
      if (hs_data[i] !== 32'h3F80_0000 + DW'(i) || hs_idx[i] != i || hs_cyc[i] != s + 3 + i)
        $display("FAIL srst_word[%0d]: data=%h idx=%0d cyc=%0d want %h %0d %0d", i, hs_data[i], hs_idx[i], hs_cyc[i] - s,
                 32'h3F80_0000 + DW'(i), i, 3 + i);
      else pass_cnt++;
    end
  endtask

`ifdef DRAIN_CHECKSUM_EN
  task automatic test_checksum();
    int s;
    preload(32'h0000_0001);
    tick();
    clear_mon(); out_ready = 1'b1;
    pulse_start(s);
    for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
    total_cnt++;
    if (done !== 1'b1 || checksum !== 32'h0000_0020) $display("FAIL checksum_done: done=%b checksum=%h want 1 00000020", done, checksum);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (checksum !== 32'h0000_0020) $display("FAIL checksum_hold: got %h want 00000020", checksum);
    else pass_cnt++;
  endtask
`endif

  initial begin
    srst = 1'b1; start = 1'b0; out_ready = 1'b0;
    preload(32'h3F80_0000);
    clear_mon();
    test_reset();
    test_stream();
    test_toggle();
    test_stall();
    test_ignore_start();
    test_srst();
`ifdef DRAIN_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
